// File: rtl/sha256_message_schedule_if.sv
// Handshake bundle between the SHA-256 message schedule and its neighbours:
// word load from the block buffer and W_t delivery to the compression stage.
interface sha256_message_schedule_if;
  logic        word_valid_in;
  logic [31:0] word_in;
  logic        word_ready_out;
  logic        w_ready_in;
  logic        w_valid_out;
  logic [31:0] w_out;
  logic [6:0]  round_out;
  logic        block_done_out;

  modport master (
    input  word_valid_in, word_in, w_ready_in,
    output word_ready_out, w_valid_out, w_out, round_out, block_done_out
  );

  modport slave (
    output word_valid_in, word_in, w_ready_in,
    input  word_ready_out, w_valid_out, w_out, round_out, block_done_out
  );
endinterface

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: loads 16 message words into a sliding window and
// streams W_0..W_63 with their round index, one per consumer handshake.
module sha256_message_schedule #(
  parameter int LOAD_WORDS = 16,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  sha256_message_schedule_if.master   bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] win [16];
  logic [31:0] new_word;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'd0, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // win[0] is W_t, so win[15] receives W_{t+16}
  assign new_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= LOAD;
      cnt                <= 4'd0;
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
      bus.word_ready_out <= 1'b1;
      bus.w_valid_out    <= 1'b0;
      bus.w_out          <= 32'd0;
      bus.round_out      <= 7'd0;
      bus.block_done_out <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.word_valid_in) begin
            win[cnt] <= bus.word_in;
            cnt      <= cnt + 4'd1;
            // win[0] was written on the first accept, so it is already W_0
            if (cnt == 4'(LOAD_WORDS - 1)) begin
              state              <= EMIT;
              bus.word_ready_out <= 1'b0;
              bus.w_valid_out    <= 1'b1;
              bus.w_out          <= win[0];
              bus.round_out      <= 7'd0;
            end
          end
        end
        EMIT: begin
          if (bus.w_ready_in) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= new_word;
            if (bus.round_out == 7'(NUM_ROUNDS - 1)) begin
              state              <= DONE;
              bus.w_valid_out    <= 1'b0;
              bus.w_out          <= 32'd0;
              bus.round_out      <= 7'd0;
              bus.block_done_out <= 1'b1;
            end else begin
              bus.w_out     <= win[1];
              bus.round_out <= bus.round_out + 7'd1;
            end
          end
        end
        DONE: begin
          state              <= LOAD;
          cnt                <= 4'd0;
          bus.block_done_out <= 1'b0;
          bus.word_ready_out <= 1'b1;
        end
        default: begin
          state              <= LOAD;
          cnt                <= 4'd0;
          bus.word_ready_out <= 1'b1;
          bus.w_valid_out    <= 1'b0;
          bus.w_out          <= 32'd0;
          bus.round_out      <= 7'd0;
          bus.block_done_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Directed bench for sha256_message_schedule: "abc" and all-zero blocks with
// gapped loads, consumer stalls, mid-block reset and junk input during emit.
module tb_sha256_message_schedule;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_message_schedule_if ifc ();

  sha256_message_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    int          rnd;
    logic [31:0] w;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] cap_w [64];
  vec_t        tbl   [5];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule over a flat 64-entry array
  function automatic void compute_model();
    for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
               + exp_w[i-7]
               + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
               + exp_w[i-16];
  endfunction

  function automatic void set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    compute_model();
  endfunction

  function automatic void set_zero();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    compute_model();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_word_ready"}, 32'(ifc.word_ready_out), 32'd1);
    check({tag, "_w_valid"},    32'(ifc.w_valid_out),    32'd0);
    check({tag, "_w_out"},      ifc.w_out,               32'd0);
    check({tag, "_round"},      32'(ifc.round_out),      32'd0);
    check({tag, "_done"},       32'(ifc.block_done_out), 32'd0);
  endtask

  task automatic load_block(input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < 16 && cyc < 100) begin
      rdy = ifc.word_ready_out;
      ifc.word_valid_in = toggle ? (cyc % 2 == 0) : 1'b1;
      ifc.word_in       = msg[idx];
      @(posedge clk); #1;
      cyc++;
      if (ifc.word_valid_in && rdy) idx++;
    end
    ifc.word_valid_in = 1'b0;
    check("load_words", 32'(idx), 32'd16);
    check("load_cycles", 32'(cyc), toggle ? 32'd31 : 32'd16);
    check("first_valid", 32'(ifc.w_valid_out), 32'd1);
  endtask

  task automatic emit_block(input int stall_at, input int stall_len, input bit junk, input int rst_at);
    int t = 0;
    int stalls = 0;
    int budget = 0;
    ifc.w_ready_in = 1'b1;
    while (t < 64 && budget < 300) begin
      ifc.word_valid_in = junk;
      ifc.word_in       = junk ? $urandom : 32'd0;
      check($sformatf("w_valid_t%0d", t), 32'(ifc.w_valid_out), 32'd1);
      check($sformatf("round_t%0d", t),   32'(ifc.round_out),   32'(t));
      check($sformatf("w_t%0d", t),       ifc.w_out,            exp_w[t]);
      cap_w[t] = ifc.w_out;
      if (t == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ifc.word_valid_in = 1'b0;
        check_idle_reset("mid_rst");
        return;
      end
      if (t == stall_at && stalls < stall_len) begin
        ifc.w_ready_in = 1'b0;
        stalls++;
      end else begin
        ifc.w_ready_in = 1'b1;
        t++;
      end
      @(posedge clk); #1;
      budget++;
    end
    check("emit_budget", 32'(t), 32'd64);
    ifc.w_ready_in = 1'b0;
    check("done_pulse",       32'(ifc.block_done_out), 32'd1);
    check("done_w_valid",     32'(ifc.w_valid_out),    32'd0);
    check("done_word_ready",  32'(ifc.word_ready_out), 32'd0);
    check("done_w_out",       ifc.w_out,               32'd0);
    check("done_round",       32'(ifc.round_out),      32'd0);
    @(posedge clk); #1;
    ifc.word_valid_in = 1'b0;
    check("post_done_pulse", 32'(ifc.block_done_out), 32'd0);
    check("post_done_ready", 32'(ifc.word_ready_out), 32'd1);
    check("post_done_valid", 32'(ifc.w_valid_out),    32'd0);
    ifc.w_ready_in = 1'b1;
  endtask

  initial begin
    tbl[0] = '{rnd: 0,  w: 32'h61626380};
    tbl[1] = '{rnd: 15, w: 32'h00000018};
    tbl[2] = '{rnd: 16, w: 32'h61626380};
    tbl[3] = '{rnd: 17, w: 32'h000f0000};
    tbl[4] = '{rnd: 63, w: 32'h12b1edeb};

    ifc.word_valid_in = 1'b0;
    ifc.word_in       = 32'd0;
    ifc.w_ready_in    = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_reset("reset");

    // abc block, no stalls, plus known-answer words
    set_abc();
    load_block(1'b0);
    emit_block(-1, 0, 1'b0, -1);
    for (int i = 0; i < 5; i++)
      check($sformatf("kat_w%0d", tbl[i].rnd), cap_w[tbl[i].rnd], tbl[i].w);

    // gapped load
    load_block(1'b1);
    emit_block(-1, 0, 1'b0, -1);

    // consumer stall at t=20
    load_block(1'b0);
    emit_block(20, 5, 1'b0, -1);

    // reset at t=30 then full reload
    load_block(1'b0);
    emit_block(-1, 0, 1'b0, 30);
    load_block(1'b0);
    emit_block(-1, 0, 1'b0, -1);

    // junk on the load port during emit and done
    load_block(1'b0);
    emit_block(-1, 0, 1'b1, -1);
    load_block(1'b0);
    emit_block(-1, 0, 1'b0, -1);

    // back-to-back abc then all-zero block
    load_block(1'b0);
    emit_block(-1, 0, 1'b0, -1);
    set_zero();
    load_block(1'b0);
    emit_block(-1, 0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
